// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and keeps at most one request to instruction memory
// in flight. It hands {instr, pc} to IF/ID and honours ID stall and EX redirect.
module if_stage_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      instrF_o,
  output logic [31:0]      pcF_o,
  output logic             validF_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_seq;
  logic        xfer;

  assign pc_seq = pcF_o + 32'd4;

  always_comb begin
    state_d     = state_q;
    imem_req_o  = 1'b0;
    imem_addr_o = 32'h0;
    xfer        = 1'b0;
    if (!rst_i) begin
      state_d = S_REQ;
    end else if (redirect_i) begin
      // A response still in flight must be swallowed before the next request may go out
      state_d = ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid_i) ? S_DRAIN : S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          imem_req_o  = 1'b1;
          imem_addr_o = pc_q;
          state_d     = S_WAIT;
        end
        S_WAIT:  if (imem_rvalid_i) state_d = S_HOLD;
        S_HOLD: begin
          if (!stall_i) begin
            xfer        = 1'b1;
            imem_req_o  = 1'b1;
            imem_addr_o = pc_seq;
            state_d     = S_WAIT;
          end
        end
        S_DRAIN: if (imem_rvalid_i) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      instrF_o    <= 32'h0;
      pcF_o       <= 32'h0;
      validF_o    <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        validF_o <= 1'b0;
        pc_q     <= redirect_pc_i & ~32'h3;
      end else if (state_q == S_WAIT && imem_rvalid_i) begin
        instrF_o <= imem_rdata_i;
        pcF_o    <= pc_q;
        validF_o <= 1'b1;
      end else if (xfer) begin
        pc_q        <= pc_seq;
        fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
        validF_o    <= 1'b0;
      end
    end
  end

endmodule
